// File: rtl/matrix_vec_pow_ctrl.sv
// Computes u = M^k * v over GF(2) by applying the 2x2 matrix-vector multiply core once per clock.
// Jobs arrive on a valid/ready handshake; the result and step count leave on another.

module matrix_vec_mul (
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic d,
    input  logic e,
    input  logic f,
    output logic g,
    output logic h
);
    assign g = (a & e) ^ (b & f);
    assign h = (c & e) ^ (d & f);
endmodule

module matrix_vec_pow_ctrl #(
    parameter int CNT_W      = 4,
    parameter int EARLY_EXIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             m_a,
    input  logic             m_b,
    input  logic             m_c,
    input  logic             m_d,
    input  logic             v_e,
    input  logic             v_f,
    input  logic [CNT_W-1:0] k,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_g,
    output logic             out_h,
    output logic [CNT_W-1:0] out_steps
);
    // state | meaning
    // IDLE  | waiting for a job, in_ready high
    // RUN   | one core application per clock until cnt runs out or vreg is zero
    // DONE  | result presented, waiting for out_ready
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic EE = (EARLY_EXIT != 0);

    state_t           state;
    state_t           state_nxt;
    logic [3:0]       mreg;
    logic [1:0]       vreg;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] steps;
    logic             core_g;
    logic             core_h;
    logic             zero_stop;
    logic             last_step;

    matrix_vec_mul u_core (
        .a (mreg[3]),
        .b (mreg[2]),
        .c (mreg[1]),
        .d (mreg[0]),
        .e (vreg[1]),
        .f (vreg[0]),
        .g (core_g),
        .h (core_h)
    );

    // The zero vector is a fixed point of any matrix, so further steps are wasted.
    assign zero_stop = EE && (vreg == 2'b00);
    assign last_step = (cnt == CNT_W'(1));

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_nxt = (k == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (zero_stop || last_step) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mreg      <= '0;
            vreg      <= '0;
            cnt       <= '0;
            steps     <= '0;
            out_g     <= 1'b0;
            out_h     <= 1'b0;
            out_steps <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mreg  <= {m_a, m_b, m_c, m_d};
                        vreg  <= {v_e, v_f};
                        cnt   <= k;
                        steps <= '0;
                        if (k == '0) begin
                            out_g     <= v_e;
                            out_h     <= v_f;
                            out_steps <= '0;
                        end
                    end
                end
                RUN: begin
                    if (zero_stop) begin
                        out_g     <= vreg[1];
                        out_h     <= vreg[0];
                        out_steps <= steps;
                    end else begin
                        vreg  <= {core_g, core_h};
                        cnt   <= cnt - CNT_W'(1);
                        steps <= steps + CNT_W'(1);
                        // Output registers capture the final vector on the same edge that enters DONE.
                        if (last_step) begin
                            out_g     <= core_g;
                            out_h     <= core_h;
                            out_steps <= steps + CNT_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_matrix_vec_pow_ctrl.sv
// Bench for matrix_vec_pow_ctrl: table of jobs with hand-derived results, random jobs
// checked against a GF(2) model, plus backpressure, reset-abort and no-early-exit sequences.

module tb_matrix_vec_pow_ctrl;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid, in_valid0;
    logic             in_ready, in_ready0;
    logic             m_a, m_b, m_c, m_d, v_e, v_f;
    logic [CNT_W-1:0] k;
    logic             out_valid, out_valid0;
    logic             out_ready, out_ready0;
    logic             out_g, out_h, out_g0, out_h0;
    logic [CNT_W-1:0] out_steps, out_steps0;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [3:0] m;
        logic [1:0] v;
        int         kk;
        logic       g;
        logic       h;
        int         steps;
        int         lat;
    } vec_t;

    typedef struct {
        logic g;
        logic h;
        int   steps;
        int   lat;
    } exp_t;

    vec_t vecs[7];
    exp_t sb[$];

    always #5 clk = ~clk;

    matrix_vec_pow_ctrl #(.CNT_W(CNT_W), .EARLY_EXIT(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .m_a(m_a), .m_b(m_b), .m_c(m_c), .m_d(m_d), .v_e(v_e), .v_f(v_f), .k(k),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_g(out_g), .out_h(out_h), .out_steps(out_steps)
    );

    matrix_vec_pow_ctrl #(.CNT_W(CNT_W), .EARLY_EXIT(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0),
        .m_a(m_a), .m_b(m_b), .m_c(m_c), .m_d(m_d), .v_e(v_e), .v_f(v_f), .k(k),
        .out_valid(out_valid0), .out_ready(out_ready0),
        .out_g(out_g0), .out_h(out_h0), .out_steps(out_steps0)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [3:0] m, input logic [1:0] v, input int kk);
        exp_t       e;
        logic [1:0] vv;
        bit         exited;
        vv     = v;
        exited = 0;
        e.steps = 0;
        e.lat   = kk;
        for (int i = 0; i < kk; i++) begin
            if (vv == 2'b00) begin
                e.lat  = i + 1;
                exited = 1;
                break;
            end
            vv = {(m[3] & vv[1]) ^ (m[2] & vv[0]), (m[1] & vv[1]) ^ (m[0] & vv[0])};
            e.steps = i + 1;
        end
        if (!exited) e.lat = kk;
        e.g = vv[1];
        e.h = vv[0];
        return e;
    endfunction

    task automatic drive_job(input logic [3:0] m, input logic [1:0] v, input int kk);
        {m_a, m_b, m_c, m_d} = m;
        {v_e, v_f} = v;
        k = CNT_W'(kk);
    endtask

    // Offers a job from IDLE; returns just after the accepting edge.
    task automatic start_job(input string name, input logic [3:0] m, input logic [1:0] v,
                             input int kk, input exp_t e);
        @(negedge clk);
        chk({name, "_ready_before"}, int'(in_ready), 1);
        drive_job(m, v, kk);
        in_valid = 1'b1;
        sb.push_back(e);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_result(input string name, input bit chk_busy);
        exp_t e;
        int   n;
        bit   saw_ready;
        e = sb.pop_front();
        n = 0;
        saw_ready = 0;
        @(negedge clk);
        while (!out_valid && n < 100) begin
            if (in_ready) saw_ready = 1;
            @(negedge clk);
            n++;
        end
        chk({name, "_latency"}, n, e.lat);
        chk({name, "_g"}, int'(out_g), int'(e.g));
        chk({name, "_h"}, int'(out_h), int'(e.h));
        chk({name, "_steps"}, int'(out_steps), e.steps);
        if (chk_busy) chk({name, "_ready_low_in_run"}, int'(saw_ready), 0);
    endtask

    task automatic ack(input string name);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        chk({name, "_valid_after_ack"}, int'(out_valid), 0);
        chk({name, "_ready_after_ack"}, int'(in_ready), 1);
    endtask

    initial begin
        exp_t       e;
        logic [3:0] rm;
        logic [1:0] rv;
        int         rk, n;

        //          M=[[a,b],[c,d]]  v      k   g     h     steps lat
        vecs[0] = '{4'b1101, 2'b01, 1,  1'b1, 1'b1, 1,  1};
        vecs[1] = '{4'b1101, 2'b01, 2,  1'b0, 1'b1, 2,  2};
        vecs[2] = '{4'b0111, 2'b10, 0,  1'b1, 1'b0, 0,  0};
        vecs[3] = '{4'b1000, 2'b01, 5,  1'b0, 1'b0, 1,  2};
        vecs[4] = '{4'b1000, 2'b00, 5,  1'b0, 1'b0, 0,  1};
        vecs[5] = '{4'b0111, 2'b10, 15, 1'b1, 1'b0, 15, 15};
        vecs[6] = '{4'b1111, 2'b11, 3,  1'b0, 1'b0, 1,  2};

        rst = 1'b1;
        in_valid = 1'b0; in_valid0 = 1'b0;
        out_ready = 1'b0; out_ready0 = 1'b0;
        drive_job(4'b0000, 2'b00, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_in_ready", int'(in_ready), 1);
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_out_g", int'(out_g), 0);
        chk("reset_out_h", int'(out_h), 0);
        chk("reset_out_steps", int'(out_steps), 0);

        for (int i = 0; i < 7; i++) begin
            e.g = vecs[i].g; e.h = vecs[i].h; e.steps = vecs[i].steps; e.lat = vecs[i].lat;
            start_job($sformatf("vec%0d", i), vecs[i].m, vecs[i].v, vecs[i].kk, e);
            wait_result($sformatf("vec%0d", i), 1'b1);
            ack($sformatf("vec%0d", i));
        end

        for (int i = 0; i < 8; i++) begin
            rm = 4'($urandom_range(0, 15));
            rv = 2'($urandom_range(0, 3));
            rk = $urandom_range(0, 15);
            start_job($sformatf("rnd%0d", i), rm, rv, rk, model(rm, rv, rk));
            wait_result($sformatf("rnd%0d", i), 1'b1);
            ack($sformatf("rnd%0d", i));
        end

        // Backpressure: result must hold and a pending job must wait for IDLE.
        e.g = 1'b1; e.h = 1'b0; e.steps = 15; e.lat = 15;
        start_job("bp", 4'b0111, 2'b10, 15, e);
        wait_result("bp", 1'b1);
        drive_job(4'b1101, 2'b01, 1);
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_hold_valid", int'(out_valid), 1);
            chk("bp_hold_g", int'(out_g), 1);
            chk("bp_hold_h", int'(out_h), 0);
            chk("bp_hold_steps", int'(out_steps), 15);
            chk("bp_hold_in_ready", int'(in_ready), 0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        chk("bp_idle_in_ready", int'(in_ready), 1);
        chk("bp_idle_out_valid", int'(out_valid), 0);
        e.g = 1'b1; e.h = 1'b1; e.steps = 1; e.lat = 1;
        sb.push_back(e);
        @(posedge clk);
        #1 in_valid = 1'b0;
        wait_result("bp_next", 1'b1);
        ack("bp_next");

        // Asynchronous reset between edges while a long job runs.
        e.g = 1'b1; e.h = 1'b0; e.steps = 15; e.lat = 15;
        start_job("abort", 4'b0111, 2'b10, 15, e);
        void'(sb.pop_front());
        repeat (4) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("abort_out_valid", int'(out_valid), 0);
        chk("abort_in_ready", int'(in_ready), 1);
        @(negedge clk);
        rst = 1'b0;
        e.g = 1'b1; e.h = 1'b1; e.steps = 1; e.lat = 1;
        start_job("post_rst", 4'b1101, 2'b01, 1, e);
        wait_result("post_rst", 1'b1);
        ack("post_rst");

        // Same zero-vector job without early exit runs all k steps.
        @(negedge clk);
        chk("ee0_ready", int'(in_ready0), 1);
        drive_job(4'b1000, 2'b00, 5);
        in_valid0 = 1'b1;
        @(posedge clk);
        #1 in_valid0 = 1'b0;
        n = 0;
        @(negedge clk);
        while (!out_valid0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("ee0_latency", n, 5);
        chk("ee0_steps", int'(out_steps0), 5);
        chk("ee0_g", int'(out_g0), 0);
        chk("ee0_h", int'(out_h0), 0);
        out_ready0 = 1'b1;
        @(posedge clk);
        #1 out_ready0 = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/matrix_vec_pow_ctrl.md
Name: matrix_vec_pow_ctrl

Overview:
Sequencing controller that computes u = M^k · v over GF(2) for a 2x2 binary matrix M. It uses one instance of the team's combinational 2x2 GF(2) matrix-vector multiply core, matrix_vec_mul, which has inputs a,b,c,d,e,f and outputs g,h. The controller accepts a job over a valid/ready handshake and applies the core once per clock for k steps. It returns the result and the step count over a second valid/ready handshake. It sits between job-issuing logic and the shared multiply core.

Parameters:
CNT_W, 4, width of the exponent k and of the step counter. Legal values are 1..16.
EARLY_EXIT, 1, if 1, terminate as soon as the working vector is all-zero, because the zero vector is a fixed point. If 0, always run the full k steps.

Ports:
clk  input  1  clock, rising-edge.
rst  input  1  reset, asynchronous, active-high.
in_valid  input  1  job offered.
in_ready  output  1  controller can accept a job.
m_a, m_b, m_c, m_d  input  1 each  matrix M = [[m_a, m_b], [m_c, m_d]].
v_e, v_f  input  1 each  input vector v = (v_e, v_f).
k  input  CNT_W  number of multiply applications.
out_valid  output  1  result available.
out_ready  input  1  consumer accepts the result.
out_g, out_h  output  1 each  result vector u = (out_g, out_h).
out_steps  output  CNT_W  number of applications actually performed.

Behaviour:
- Reset is asynchronous and active-high; all registers clear immediately on assertion.
  - State = IDLE.
  - in_ready = 1 after reset.
  - out_valid = 0, out_g = 0, out_h = 0, out_steps = 0.
- Registers: state (IDLE/RUN/DONE), mreg[3:0], vreg[1:0], cnt[CNT_W-1:0], steps[CNT_W-1:0].
- The core is fed from mreg and vreg. Its g,h outputs are the next-vector value.
- IDLE:
  - in_ready = 1.
  - On an edge with in_valid = 1: latch M into mreg, v into vreg, k into cnt; set steps to 0.
  - If k == 0, go to DONE, with the result equal to v. Otherwise go to RUN.
  - Input signals are don't-care when in_valid = 0.
- RUN:
  - in_ready = 0.
  - If EARLY_EXIT = 1 and vreg == 0: go to DONE with no update.
  - Otherwise, each edge: vreg <= (g, h); cnt <= cnt - 1; steps <= steps + 1.
  - If cnt == 1 on that edge, go to DONE.
- DONE:
  - out_valid = 1.
  - out_g, out_h = vreg and out_steps = steps. All three are held stable while out_ready = 0.
  - On an edge with out_ready = 1: go to IDLE.
  - No job can be accepted in the same cycle as the result handshake. in_ready rises the cycle after.
- All outputs are driven from registers; there is no combinational path from any input to any output.
- In IDLE and RUN, out_g, out_h and out_steps keep their last DONE values; consumers ignore them when out_valid = 0.
- Latency: with the acceptance edge E0 and no early exit, out_valid is high after edge E0 + k.
  - k = 0 gives out_valid one cycle after acceptance.
  - Maximum latency is 2^CNT_W - 1 applications plus 1 cycle.
- Early exit: out_valid is high one edge after vreg becomes zero. out_steps is the count of applications done so far, and is less than k.
  - v = 0 with k > 0 gives out_steps = 0 and out_valid after E0 + 1.
- Arithmetic is mod 2 throughout.
  - The counter never underflows: RUN is only entered with cnt ≥ 1.
  - steps never exceeds k.
- Reset mid-RUN or mid-DONE aborts the job; the result is never presented.
- in_valid held high while in_ready = 0 is ignored, and its inputs are not sampled.

Test Plan:
- M = [[1,1],[0,1]], v = (0,1), k = 1 → out_g = 1, out_h = 1, out_steps = 1, out_valid after E0 + 1. Then k = 2 with the same M and v → (0,1), out_steps = 2, out_valid after E0 + 2.
- k = 0, M = [[0,1],[1,1]], v = (1,0) → (1,0), out_steps = 0, out_valid one cycle after acceptance.
- EARLY_EXIT = 1:
  - M = [[1,0],[0,0]], v = (0,1), k = 5 → (0,0), out_steps = 1, out_valid after E0 + 2.
  - v = (0,0), k = 5 → (0,0), out_steps = 0, out_valid after E0 + 1.
  - With EARLY_EXIT = 0, the same job gives out_steps = 5.
- CNT_W = 4, M = [[0,1],[1,1]] (order 3), v = (1,0), k = 15 → (1,0), out_steps = 15, out_valid exactly after E0 + 15, with in_ready = 0 throughout.
- Backpressure: hold out_ready = 0 for 3 cycles in DONE while in_valid = 1 with a new job.
  - Required: out_g, out_h and out_steps stay stable; in_ready = 0; the new job is not latched.
  - After out_ready = 1: IDLE, then the job is accepted on the next edge.
- Assert rst asynchronously mid-RUN, between clock edges → out_valid = 0 and in_ready = 1 immediately. After release, the next job (k = 1, M = [[1,1],[0,1]], v = (0,1)) returns (1,1).
